// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard: pipeline entry layout,
// select encodings and the issue-latency clamp.
package fwd_pkg;

  // Stored latency width; supports DEPTH up to 15 (SELW must not exceed LAT_W).
  localparam int unsigned LAT_W     = 4;
  localparam int unsigned FWD_RF    = 0;
  localparam int unsigned STG_EXMEM = 1;
  localparam int unsigned STG_MEMWB = 2;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rd;
    logic [LAT_W-1:0] lat;
  } entry_t;

  // Latency 0 behaves as 1; anything beyond the last tracked stage behaves as DEPTH.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat,
                                                 input int unsigned       depth);
    if (lat == '0) begin
      return LAT_W'(1);
    end else if (32'(lat) > depth) begin
      return LAT_W'(depth);
    end
    return lat;
  endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port lookup: finds the youngest in-flight writer of the source register and
// either selects its stage or flags the port as not ready.
module fwd_port_match
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1]  i_entry,
  input  logic              i_rd_valid,
  input  logic [4:0]        i_rd_addr,
  output logic [SELW-1:0]   o_sel,
  output logic              o_not_ready
);

  logic             w_hit;
  logic [LAT_W-1:0] w_stage;
  logic [LAT_W-1:0] w_lat;

  always_comb begin
    w_hit   = 1'b0;
    w_stage = '0;
    w_lat   = '0;
    // Scan oldest to youngest so the lowest matching stage overrides.
    for (int s = DEPTH; s >= 1; s--) begin
      if (i_entry[s].valid && (i_entry[s].rd == i_rd_addr)) begin
        w_hit   = 1'b1;
        w_stage = LAT_W'(s);
        w_lat   = i_entry[s].lat;
      end
    end
    w_hit = w_hit && i_rd_valid && (i_rd_addr != 5'd0);
  end

  always_comb begin
    o_sel       = SELW'(FWD_RF);
    o_not_ready = 1'b0;
    if (w_hit) begin
      if (w_stage >= w_lat) begin
        o_sel = w_stage[SELW-1:0];
      end else begin
        o_not_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shift pipeline of in-flight writers, per-port forwarding selects,
// load-use stall request and a saturating stall-cycle counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NREAD = 2,
  parameter int unsigned SELW  = $clog2(DEPTH + 1),
  parameter int unsigned CNTW  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_hold,
  input  logic                  i_flush,
  input  logic                  i_iss_regwrite,
  input  logic [4:0]            i_iss_rd,
  input  logic [SELW-1:0]       i_iss_lat,
  input  logic [NREAD-1:0]      i_rd_valid,
  input  logic [5*NREAD-1:0]    i_rd_addr,
  output logic [SELW*NREAD-1:0] o_fwd_sel,
  output logic                  o_stall,
  output logic [CNTW-1:0]       o_stall_cnt
);

  entry_t [DEPTH:1] r_entry;
  logic [CNTW-1:0]  r_stall_cnt;
  logic [NREAD-1:0] w_not_ready;
  logic             w_stall;
  entry_t           w_new;

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .SELW  (SELW)
    ) u_match (
      .i_entry     (r_entry),
      .i_rd_valid  (i_rd_valid[k]),
      .i_rd_addr   (i_rd_addr[5*k +: 5]),
      .o_sel       (o_fwd_sel[SELW*k +: SELW]),
      .o_not_ready (w_not_ready[k])
    );
  end

  // A flushed consumer is discarded, so it never needs to wait.
  assign w_stall = (|w_not_ready) && !i_flush;

  always_comb begin
    w_new.valid = i_iss_regwrite && (i_iss_rd != 5'd0) && !w_stall && !i_flush;
    w_new.rd    = i_iss_rd;
    w_new.lat   = clamp_lat(LAT_W'(i_iss_lat), DEPTH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_entry     <= '0;
      r_stall_cnt <= '0;
    end else if (!i_hold) begin
      r_entry[STG_EXMEM] <= w_new;
      for (int s = STG_EXMEM + 1; s <= DEPTH; s++) begin
        r_entry[s] <= r_entry[s-1];
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_stall     = w_stall;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the single-cycle forwarding unit.
- Holds a shift-pipeline of in-flight register writers, one entry per post-execute stage (stage 1 = EX/MEM ... stage DEPTH = last stage before register-file write).
- Each writer carries a result-ready latency, so multi-cycle producers (loads, multiplier) get a stall instead of a wrong forward.
- Drives one forwarding-mux select per read port for the ID/EX consumer, a pipeline stall request, and a stall-cycle counter.

Parameters:
DEPTH, 3, number of tracked stages after execute (>=2)
NREAD, 2, number of consumer read ports (rs, rt, ...)
SELW, $clog2(DEPTH+1), width of latency and select fields
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
hold  in  1  external pipeline freeze (memory wait); scoreboard does not advance
flush  in  1  kill ID/EX consumer this cycle
iss_regwrite  in  1  ID/EX instruction writes a register
iss_rd  in  5  ID/EX destination register
iss_lat  in  SELW  first stage (1..DEPTH) at which its result is forwardable
rd_valid  in  NREAD  port k actually reads a register
rd_addr  in  5*NREAD  port k source register, port k in bits [5k+4:5k]
fwd_sel  out  SELW*NREAD  port k mux select: 0 = register file, s = stage-s result
stall  out  1  hold IF/ID and ID/EX this cycle, insert bubble into stage 1
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- One clock, synchronous active-low reset, as already decided.
- State: entries e[1..DEPTH] of {valid, rd[4:0], lat[SELW-1:0]}; stall_cnt.
- Reset (rst_n=0 at edge): all valid=0, stall_cnt=0. Outputs after reset: fwd_sel=0, stall=0, stall_cnt=0. Reset mid-operation discards all in-flight entries, same edge.
- Advance at each edge when rst_n=1 and hold=0:
  - e[s] <= e[s-1] for s=2..DEPTH; e[DEPTH] retires.
  - e[1] <= {iss_regwrite && iss_rd!=0 && !stall && !flush, iss_rd, iss_lat}.
  - Stall or flush therefore inserts a bubble.
- hold=1: all entries and stall_cnt frozen; outputs still evaluated combinationally from frozen state.
- Lookup (combinational, zero latency) per port k with valid read (rd_valid[k]=1, rd_addr!=0):
  - Match = lowest s with e[s].valid && e[s].rd==rd_addr (youngest writer wins).
  - No match: sel=0.
  - Match with s >= e[s].lat: sel=s.
  - Match with s < e[s].lat: port not ready, sel=0. Do not fall through to older entries.
- rd_addr==0 or rd_valid[k]=0: sel=0, never not-ready.
- stall = (any port not ready) && !flush. A flushed consumer never stalls.
- iss_lat values: 0 is treated as 1; values >DEPTH are treated as DEPTH.
- Since stall inserts a bubble, a waiting entry advances one stage per non-held cycle, so stall lasts exactly lat - s cycles.
- stall_cnt: increments on edges with stall=1 && hold=0 && rst_n=1; saturates at all-ones.
- A register written by an entry retiring at stage DEPTH and read the same cycle is served by the register file (write-before-read); sel=0 next cycle.
- No X on outputs when inputs are known; unused select bits are 0.

Decomposition:
- Shared package fwd_pkg: FWD_RF=0 select constant, entry struct typedef {valid, rd, lat}, stage-index constants (STG_EXMEM=1, STG_MEMWB=2), lat clamp function.
- Sub-module fwd_port_match (one per read port, generate loop): inputs entry vector + rd_addr/rd_valid; outputs sel, not_ready.
- Top holds the shift pipeline, stall OR-reduce, counter.

Test Plan:
1. ALU back-to-back: issue rd=5 lat=1, next cycle port0 reads r5 -> fwd_sel[0]=1, stall=0.
2. Load-use: issue rd=8 lat=2, next reads r8 on port1 -> stall=1 for one cycle, then fwd_sel[1]=2, stall=0, stall_cnt=1.
3. Youngest-wins: r3 written lat=1 twice in consecutive cycles, then read -> sel=1, not 2. Writer to r0 lat=3 followed by read r0 -> sel=0, stall=0.
4. Latency-3 producer with DEPTH=3 read immediately -> stall 2 cycles. Assert hold=1 during second stall cycle -> stall persists, stall_cnt unchanged while held.
5. flush during load-use stall condition -> stall=0, bubble enters stage 1. Assert rst_n=0 with three valid entries -> next cycle reads of their regs give sel=0, stall_cnt=0.
6. CNTW=4, force 20 stall cycles -> stall_cnt holds at 15.
